// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: constants and encodings shared by the program-counter generator.
//   PC_STEP  - byte distance between sequential instructions.
//   pc_src_e - which source feeds the next program counter.
package pc_gen_pkg;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        JUMP = 2'd1,
        JALR = 2'd2,
        RET  = 2'd3
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   i_clk, i_rst_n : clock, synchronous active-low reset (pointer/count only)
//   i_push, i_pop  : push i_data / pop top; both together replace the top
//   i_data         : return address to push
//   o_top          : current top entry (meaningless while empty)
//   o_empty/o_full : decode of the registered occupancy count
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;    // next free slot; top lives at r_ptr-1
    logic [CW-1:0]   r_count;

    logic [PW-1:0]   w_top_idx;
    logic            w_swap;
    logic            w_we;
    logic [PW-1:0]   w_waddr;

    assign w_top_idx = r_ptr - PW'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(RAS_DEPTH));

    // Push+pop on a non-empty stack rewrites the top in place. On an empty
    // stack the same request degenerates to a plain push.
    assign w_swap  = i_push && i_pop && !o_empty;
    assign w_we    = i_push;
    assign w_waddr = w_swap ? w_top_idx : r_ptr;

    // Entry storage carries no reset; entries are only trusted below count.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_we)
            r_mem[w_waddr] <= i_data;
    end

    // When full, a push lands on r_ptr, which is the oldest entry, so the
    // overwrite is naturally circular and the count saturates.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_swap) begin
            r_ptr   <= r_ptr;
            r_count <= r_count;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (!o_full)
                r_count <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_ptr   <= r_ptr - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with return-address stack.
//   pc_clk, pc_rst_n     : clock, synchronous active-low reset
//   pc_stall             : freeze PC, stack and misaligned flag
//   pc_jump_enb/offset   : PC-relative redirect
//   pc_jalr_enb/target   : absolute redirect (target also backs an empty ret)
//   pc_call, pc_ret      : push return address / pop it as next PC
//   pc_counter           : registered current PC
//   pc_ras_empty/full    : stack occupancy flags
//   pc_misaligned        : one cycle after a redirect with raw target[1:0]!=0
//   pc_ras_underflow     : sticky, ret seen with empty stack
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            pc_clk,
    input  logic            pc_rst_n,
    input  logic            pc_stall,
    input  logic            pc_jump_enb,
    input  logic [XLEN-1:0] pc_offset,
    input  logic            pc_jalr_enb,
    input  logic [XLEN-1:0] pc_target,
    input  logic            pc_call,
    input  logic            pc_ret,
    output logic [XLEN-1:0] pc_counter,
    output logic            pc_ras_empty,
    output logic            pc_ras_full,
    output logic            pc_misaligned,
    output logic            pc_ras_underflow
);

    logic [XLEN-1:0] r_pc;
    logic            r_misaligned;
    logic            r_underflow;

    pc_src_e         w_src;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_next;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_top;
    logic            w_empty;
    logic            w_full;

    // Next-PC select: ret > jalr > jump > sequential.
    always_comb begin
        w_src = SEQ;
        if (pc_ret)
            w_src = RET;
        else if (pc_jalr_enb)
            w_src = JALR;
        else if (pc_jump_enb)
            w_src = JUMP;

        w_seq = r_pc + XLEN'(PC_STEP);
        w_raw = w_seq;
        unique case (w_src)
            RET:     w_raw = w_empty ? pc_target : w_top;
            JALR:    w_raw = pc_target;
            JUMP:    w_raw = r_pc + pc_offset;
            default: w_raw = w_seq;
        endcase

        w_next = (w_src == SEQ) ? w_seq : {w_raw[XLEN-1:2], 2'b00};
    end

    // A call only counts alongside a taken redirect; with ret it turns the
    // pop into a top replacement (co-routine swap).
    assign w_push = !pc_stall && pc_call && (pc_ret || pc_jalr_enb || pc_jump_enb);
    assign w_pop  = !pc_stall && pc_ret;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (pc_clk),
        .i_rst_n (pc_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_seq),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge pc_clk) begin
        if (!pc_rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_misaligned <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (!pc_stall) begin
            r_pc         <= w_next;
            r_misaligned <= (w_src != SEQ) && (w_raw[1:0] != 2'b00);
            if (pc_ret && w_empty)
                r_underflow <= 1'b1;
        end
    end

    assign pc_counter       = r_pc;
    assign pc_ras_empty     = w_empty;
    assign pc_ras_full      = w_full;
    assign pc_misaligned    = r_misaligned;
    assign pc_ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, stall, jmp_e, jalr_e, call, ret;
    logic [31:0] offset, target;
    logic [31:0] pc;
    logic        empty, full, mis, unf;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
        .pc_clk           (clk),
        .pc_rst_n         (rst_n),
        .pc_stall         (stall),
        .pc_jump_enb      (jmp_e),
        .pc_offset        (offset),
        .pc_jalr_enb      (jalr_e),
        .pc_target        (target),
        .pc_call          (call),
        .pc_ret           (ret),
        .pc_counter       (pc),
        .pc_ras_empty     (empty),
        .pc_ras_full      (full),
        .pc_misaligned    (mis),
        .pc_ras_underflow (unf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC plus a return-address list.
    logic [31:0] m_pc;
    logic [31:0] stk[$];
    bit          m_mis, m_unf;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        logic [31:0] raw;
        logic [31:0] link;
        bit          redir;
        if (!rst_n) begin
            m_pc = 32'h0;
            stk.delete();
            m_mis = 1'b0;
            m_unf = 1'b0;
            m_valid = 1'b1;
        end else if (!stall) begin
            link  = m_pc + 32'd4;
            redir = 1'b1;
            raw   = link;
            if (ret) begin
                if (stk.size() > 0) begin
                    raw = stk[$];
                    void'(stk.pop_back());
                end else begin
                    raw = target;
                    m_unf = 1'b1;
                end
                if (call) stk.push_back(link);
            end else if (jalr_e || jmp_e) begin
                raw = jalr_e ? target : m_pc + offset;
                if (call) begin
                    if (stk.size() == DEPTH) void'(stk.pop_front());
                    stk.push_back(link);
                end
            end else begin
                redir = 1'b0;
            end
            m_mis = redir && (raw[1:0] != 2'b00);
            m_pc  = redir ? (raw & 32'hFFFF_FFFC) : link;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc",    pc,    m_pc);
            chk("model_empty", empty, 32'(stk.size() == 0));
            chk("model_full",  full,  32'(stk.size() == DEPTH));
            chk("model_mis",   mis,   32'(m_mis));
            chk("model_unf",   unf,   32'(m_unf));
        end
    end

    task automatic step(input bit r_n, input bit st, input bit j, input logic [31:0] off,
                        input bit jr, input logic [31:0] tgt, input bit c, input bit rt);
        rst_n = r_n; stall = st; jmp_e = j; offset = off;
        jalr_e = jr; target = tgt; call = c; ret = rt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();                                   step(1, 0, 0, 0,   0, 0,   0, 0); endtask
    task automatic do_jump(input logic [31:0] o, input bit c); step(1, 0, 1, o,   0, 0,   c, 0); endtask
    task automatic do_jalr(input logic [31:0] t, input bit c); step(1, 0, 0, 0,   1, t,   c, 0); endtask
    task automatic do_ret(input logic [31:0] t, input bit c);  step(1, 0, 0, 0,   0, t,   c, 1); endtask

    initial begin
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_empty", empty, 32'h1);
        chk("rst_unf", unf, 32'h0);
        idle(); chk("seq_4", pc, 32'h4);
        idle(); chk("seq_8", pc, 32'h8);
        idle(); chk("seq_c", pc, 32'hC);

        do_jalr(32'h100, 0);            chk("jalr_100", pc, 32'h100);
        do_jump(32'hFFFF_FFF0, 0);      chk("jump_back", pc, 32'hF0);
        step(1, 1, 1, 32'h40, 0, 0, 1, 0);
        chk("stall_hold", pc, 32'hF0);
        chk("stall_empty", empty, 32'h1);

        do_jalr(32'h200, 0);
        do_jalr(32'h1003, 1);
        chk("call_pc", pc, 32'h1000);
        chk("call_mis", mis, 32'h1);
        idle();
        chk("mis_clear", mis, 32'h0);
        chk("after_call", pc, 32'h1004);
        do_ret(32'h0, 0);
        chk("ret_pc", pc, 32'h204);
        chk("ret_empty", empty, 32'h1);

        do_jalr(32'h10, 0);
        for (int i = 0; i < 5; i++) do_jump(32'h10, 1);
        chk("nest_pc", pc, 32'h60);
        chk("nest_full", full, 32'h1);
        step(1, 1, 0, 0, 0, 32'h900, 0, 1);
        chk("stall_ret", pc, 32'h60);
        do_ret(32'h0, 0); chk("ret_54", pc, 32'h54);
        do_ret(32'h0, 0); chk("ret_44", pc, 32'h44);
        do_ret(32'h0, 0); chk("ret_34", pc, 32'h34);
        do_ret(32'h0, 0); chk("ret_24", pc, 32'h24);
        chk("drained", empty, 32'h1);
        do_ret(32'h800, 0);
        chk("uf_pc", pc, 32'h800);
        chk("uf_flag", unf, 32'h1);
        idle();
        chk("uf_sticky", unf, 32'h1);

        do_jalr(32'h500, 0);
        do_jump(32'h0, 1);
        do_jalr(32'h300, 0);
        do_ret(32'h0, 1);
        chk("swap_pc", pc, 32'h504);
        chk("swap_empty", empty, 32'h0);
        chk("swap_full", full, 32'h0);
        do_ret(32'h0, 0);
        chk("swap_top", pc, 32'h304);
        chk("swap_drain", empty, 32'h1);

        do_jalr(32'hFFFF_FFFC, 0);
        idle();
        chk("wrap", pc, 32'h0);
        chk("wrap_mis", mis, 32'h0);
        do_jump(32'h8, 1);
        chk("pre_rst_empty", empty, 32'h0);
        step(0, 0, 0, 0, 0, 32'h40, 0, 1);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_empty", empty, 32'h1);
        chk("mid_rst_unf", unf, 32'h0);
        idle();
        chk("post_rst", pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
